// File: rtl/noc_egress_pkt_fifo.sv
// rtl/noc_egress_pkt_fifo.sv - NoC egress beat FIFO with optional packet store-and-forward
module noc_egress_pkt_fifo #(
    parameter int W         = 8,
    parameter int DEPTH     = 64,
    parameter int PKT_MODE  = 0,
    parameter int AF_THRESH = DEPTH - 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       noc_from_dev_ctl,
    input  logic [W-1:0]               noc_from_dev_data,
    input  logic                       re,
    output logic                       full,
    output logic                       almost_full,
    output logic                       empty,
    output logic                       from_fifo_to_tb_ctl,
    output logic [W-1:0]               from_fifo_to_tb_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                ovf_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

    typedef enum logic [1:0] {S_IDLE, S_IN_PKT, S_DROP} state_t;

    state_t          state_q, state_d;
    logic [W:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, cm_ptr;
    logic [CW-1:0]   cm_count;
    logic [CW-1:0]   pkt_len;
    logic [CW-1:0]   count_d, cm_count_d;
    logic [AW-1:0]   wr_ptr_d;
    logic            is_idle, pop, has_slot;
    logic            do_push, do_commit, do_rollback;
    logic [16:0]     ovf_inc, ovf_sum;

    // cm_count holds only poppable entries; in stream mode it simply mirrors count
    assign empty       = (cm_count == '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= AF_C);

    always_comb begin
        is_idle     = noc_from_dev_ctl && (noc_from_dev_data == '0);
        pop         = re && !empty;
        has_slot    = (count != DEPTH_C) || pop;
        state_d     = state_q;
        do_push     = 1'b0;
        do_commit   = 1'b0;
        do_rollback = 1'b0;
        ovf_inc     = '0;
        if (PKT_MODE == 0) begin
            if (!is_idle) begin
                if (has_slot) do_push = 1'b1;
                else          ovf_inc = 17'd1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!is_idle) begin
                        if (has_slot) begin
                            do_push = 1'b1;
                            state_d = S_IN_PKT;
                        end else begin
                            ovf_inc = 17'd1;
                            state_d = S_DROP;
                        end
                    end
                end
                S_IN_PKT: begin
                    if (is_idle) begin
                        do_commit = 1'b1;
                        state_d   = S_IDLE;
                    end else if (has_slot) begin
                        do_push = 1'b1;
                    end else begin
                        do_rollback = 1'b1;
                        ovf_inc     = 17'(pkt_len) + 17'd1;
                        state_d     = S_DROP;
                    end
                end
                S_DROP: begin
                    if (is_idle) state_d = S_IDLE;
                    else         ovf_inc = 17'd1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ovf_sum = {1'b0, ovf_cnt} + ovf_inc;
        if (do_rollback) begin
            count_d  = count - pkt_len - CW'(pop);
            wr_ptr_d = cm_ptr;
        end else begin
            count_d  = count + CW'(do_push) - CW'(pop);
            wr_ptr_d = wr_ptr + AW'(do_push);
        end
        if (PKT_MODE == 0)
            cm_count_d = count_d;
        else
            cm_count_d = cm_count - CW'(pop) + (do_commit ? pkt_len : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q              <= S_IDLE;
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            cm_ptr               <= '0;
            count                <= '0;
            cm_count             <= '0;
            pkt_len              <= '0;
            ovf_cnt              <= '0;
            from_fifo_to_tb_ctl  <= 1'b1;
            from_fifo_to_tb_data <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr   <= wr_ptr_d;
            count    <= count_d;
            cm_count <= cm_count_d;
            ovf_cnt  <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (PKT_MODE == 0)  cm_ptr <= wr_ptr_d;
            else if (do_commit) cm_ptr <= wr_ptr;
            if (do_commit || do_rollback)       pkt_len <= '0;
            else if (do_push && PKT_MODE != 0)  pkt_len <= pkt_len + CW'(1);
            if (pop) begin
                from_fifo_to_tb_ctl  <= mem[rd_ptr][W];
                from_fifo_to_tb_data <= mem[rd_ptr][W-1:0];
            end else begin
                from_fifo_to_tb_ctl  <= 1'b1;
                from_fifo_to_tb_data <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {noc_from_dev_ctl, noc_from_dev_data};
    end

endmodule

// File: tb/tb_noc_egress_pkt_fifo.sv
// tb/tb_noc_egress_pkt_fifo.sv - directed bench for stream and packet mode egress FIFO
module tb_noc_egress_pkt_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_ctl, p_ctl, s_re, p_re;
    logic [7:0] s_data, p_data;
    logic       s_full, s_af, s_empty, s_octl;
    logic       p_full, p_af, p_empty, p_octl;
    logic [7:0] s_odata, p_odata;
    logic [3:0] s_count, p_count;
    logic [15:0] s_ovf, p_ovf;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    noc_egress_pkt_fifo #(.W(8), .DEPTH(8), .PKT_MODE(0)) u_stream (
        .clk(clk), .reset(reset),
        .noc_from_dev_ctl(s_ctl), .noc_from_dev_data(s_data), .re(s_re),
        .full(s_full), .almost_full(s_af), .empty(s_empty),
        .from_fifo_to_tb_ctl(s_octl), .from_fifo_to_tb_data(s_odata),
        .count(s_count), .ovf_cnt(s_ovf)
    );

    noc_egress_pkt_fifo #(.W(8), .DEPTH(8), .PKT_MODE(1)) u_pkt (
        .clk(clk), .reset(reset),
        .noc_from_dev_ctl(p_ctl), .noc_from_dev_data(p_data), .re(p_re),
        .full(p_full), .almost_full(p_af), .empty(p_empty),
        .from_fifo_to_tb_ctl(p_octl), .from_fifo_to_tb_data(p_odata),
        .count(p_count), .ovf_cnt(p_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic s_beat(input logic c, input logic [7:0] d);
        s_ctl = c; s_data = d;
        step();
        s_ctl = 1'b1; s_data = 8'h00;
    endtask

    task automatic p_beat(input logic c, input logic [7:0] d);
        p_ctl = c; p_data = d;
        step();
        p_ctl = 1'b1; p_data = 8'h00;
    endtask

    initial begin
        logic [7:0] exp_q [$];
        reset = 1'b1;
        s_ctl = 1'b1; s_data = 8'h00; s_re = 1'b0;
        p_ctl = 1'b1; p_data = 8'h00; p_re = 1'b0;
        step(); step();
        reset = 1'b0;

        check("rst_ctl",   {31'd0, s_octl}, 32'd1);
        check("rst_data",  {24'd0, s_odata}, 32'd0);
        check("rst_empty", {31'd0, s_empty}, 32'd1);
        check("rst_full",  {31'd0, s_full}, 32'd0);
        check("rst_af",    {31'd0, s_af}, 32'd0);
        check("rst_count", {28'd0, s_count}, 32'd0);
        check("rst_ovf",   {16'd0, s_ovf}, 32'd0);
        check("rst_p_empty", {31'd0, p_empty}, 32'd1);

        // T1 stream fill, overflow, drain
        for (int i = 0; i < 8; i++) s_beat(1'b0, 8'h11 + 8'(i));
        check("t1_full",  {31'd0, s_full}, 32'd1);
        check("t1_af",    {31'd0, s_af}, 32'd1);
        check("t1_count", {28'd0, s_count}, 32'd8);
        s_beat(1'b0, 8'h99);
        check("t1_ovf",   {16'd0, s_ovf}, 32'd1);
        check("t1_count9", {28'd0, s_count}, 32'd8);
        s_re = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t1_pop_data", {24'd0, s_odata}, 32'h11 + 32'(i));
            check("t1_pop_ctl",  {31'd0, s_octl}, 32'd0);
        end
        s_re = 1'b0;
        check("t1_empty", {31'd0, s_empty}, 32'd1);
        step();
        check("t1_idle_ctl",  {31'd0, s_octl}, 32'd1);
        check("t1_idle_data", {24'd0, s_odata}, 32'd0);

        // T2 idle filtering
        s_beat(1'b1, 8'h00); s_beat(1'b0, 8'hA5); s_beat(1'b1, 8'h00);
        s_beat(1'b0, 8'h5A); s_beat(1'b1, 8'h00);
        check("t2_count", {28'd0, s_count}, 32'd2);
        s_re = 1'b1;
        step(); check("t2_pop0", {23'd0, s_octl, s_odata}, 32'h0A5);
        step(); check("t2_pop1", {23'd0, s_octl, s_odata}, 32'h05A);
        step(); check("t2_empty_re", {23'd0, s_octl, s_odata}, 32'h100);
        s_re = 1'b0;

        // T5 push and pop at full
        for (int i = 0; i < 8; i++) s_beat(1'b0, 8'h21 + 8'(i));
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h21 + 8'(i));
        s_re = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_ctl = 1'b0; s_data = 8'h31 + 8'(i);
            exp_q.push_back(8'h31 + 8'(i));
            step();
            check("t5_data",  {24'd0, s_odata}, {24'd0, exp_q.pop_front()});
            check("t5_count", {28'd0, s_count}, 32'd8);
            check("t5_ovf",   {16'd0, s_ovf}, 32'd1);
        end
        s_ctl = 1'b1; s_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t5_drain", {24'd0, s_odata}, {24'd0, exp_q.pop_front()});
        end
        s_re = 1'b0;
        check("t5_empty", {31'd0, s_empty}, 32'd1);

        // T3 packet held until terminating idle
        p_beat(1'b1, 8'h42);
        check("t3_empty_a", {31'd0, p_empty}, 32'd1);
        p_beat(1'b0, 8'h01);
        p_beat(1'b0, 8'h02);
        check("t3_empty_b", {31'd0, p_empty}, 32'd1);
        check("t3_count",   {28'd0, p_count}, 32'd3);
        p_re = 1'b1;
        step();
        check("t3_no_pop", {23'd0, p_octl, p_odata}, 32'h100);
        p_re = 1'b0;
        p_beat(1'b1, 8'h00);
        check("t3_empty_c", {31'd0, p_empty}, 32'd0);
        p_re = 1'b1;
        step(); check("t3_pop0", {23'd0, p_octl, p_odata}, 32'h142);
        step(); check("t3_pop1", {23'd0, p_octl, p_odata}, 32'h001);
        step(); check("t3_pop2", {23'd0, p_octl, p_odata}, 32'h002);
        p_re = 1'b0;
        check("t3_empty_d", {31'd0, p_empty}, 32'd1);

        // T4 oversize packet discarded whole
        for (int i = 0; i < 8; i++) p_beat(1'b0, 8'h50 + 8'(i));
        check("t4_full8", {31'd0, p_full}, 32'd1);
        check("t4_empty8", {31'd0, p_empty}, 32'd1);
        p_beat(1'b0, 8'h58);
        p_beat(1'b0, 8'h59);
        p_beat(1'b1, 8'h00);
        check("t4_count", {28'd0, p_count}, 32'd0);
        check("t4_ovf",   {16'd0, p_ovf}, 32'd10);
        check("t4_empty", {31'd0, p_empty}, 32'd1);
        p_beat(1'b0, 8'h61); p_beat(1'b0, 8'h62); p_beat(1'b0, 8'h63);
        p_beat(1'b1, 8'h00);
        check("t4_count2", {28'd0, p_count}, 32'd3);
        check("t4_empty2", {31'd0, p_empty}, 32'd0);
        p_re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_pop", {23'd0, p_octl, p_odata}, 32'h061 + 32'(i));
        end
        p_re = 1'b0;
        check("t4_ovf2", {16'd0, p_ovf}, 32'd10);

        // T6 reset mid-packet
        p_beat(1'b0, 8'h71); p_beat(1'b0, 8'h72); p_beat(1'b1, 8'h00);
        p_beat(1'b0, 8'h73);
        check("t6_pre_count", {28'd0, p_count}, 32'd3);
        check("t6_pre_empty", {31'd0, p_empty}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_count", {28'd0, p_count}, 32'd0);
        check("t6_empty", {31'd0, p_empty}, 32'd1);
        check("t6_out",   {23'd0, p_octl, p_odata}, 32'h100);
        check("t6_ovf",   {16'd0, p_ovf}, 32'd0);
        check("t6_s_count", {28'd0, s_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
